// File: rtl/bus_sync_scan_ctrl.sv
// Round-robin stability qualifier for N_CH async quasi-static buses entering dest_clk.
// Latency: 2-flop front end, then 1+SETTLE+(STABLE_CNT+1)+1 cycles from SELECT to sync_valid.
// No backpressure: free-running scan, results are 1-cycle pulses plus held output registers.
module bus_sync_scan_ctrl #(
    parameter int Bus_BW     = 8,
    parameter int N_CH       = 4,
    parameter int SETTLE     = 2,
    parameter int STABLE_CNT = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                       dest_clk,
    input  logic                       dest_rst,
    input  logic [N_CH-1:0]            ch_en,
    input  logic [N_CH*Bus_BW-1:0]     Bus_in_flat,
    output logic [N_CH*Bus_BW-1:0]     Bus_sync_flat,
    output logic [N_CH-1:0]            sync_valid,
    output logic [N_CH-1:0]            sync_chg,
    output logic [N_CH-1:0]            ch_timeout,
    output logic                       busy,
    output logic [$clog2(N_CH)-1:0]    cur_ch
);

    localparam int CW = $clog2(N_CH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    STABLE_L    = 4'(STABLE_CNT);
    localparam logic [3:0]    SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [TW-1:0] TMO_L       = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_SAMPLE, S_CAPTURE, S_ABANDON
    } state_t;

    state_t state, state_nxt;

    logic [N_CH-1:0][Bus_BW-1:0] stage1, stage2, out_q;
    logic [Bus_BW-1:0]           sample, ref_val;
    logic [3:0]                  cnt;
    logic [TW-1:0]               tmo;
    logic                        first_smp;
    logic [CW-1:0]               last_ch, next_ch;
    logic [CW:0]                 sum;
    logic                        found, any_en, en_cur, samp_eq, stable_hit, tmo_hit;

    assign Bus_sync_flat = out_q;

    always_comb begin
        sample     = stage2[cur_ch];
        en_cur     = ch_en[cur_ch];
        any_en     = |ch_en;
        samp_eq    = !first_smp && (sample == ref_val);
        stable_hit = samp_eq && ((cnt + 4'd1) == STABLE_L);
        tmo_hit    = ((tmo + TW'(1)) == TMO_L);
    end

    // First enabled channel strictly after the last one served, wrapping.
    always_comb begin
        next_ch = last_ch;
        found   = 1'b0;
        sum     = '0;
        for (int i = 1; i <= N_CH; i++) begin
            sum = {1'b0, last_ch} + (CW+1)'(i);
            if (sum >= (CW+1)'(N_CH))
                sum = sum - (CW+1)'(N_CH);
            if (!found && ch_en[sum[CW-1:0]]) begin
                next_ch = sum[CW-1:0];
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (any_en) state_nxt = S_SELECT;
            S_SELECT: begin
                if (!any_en)          state_nxt = S_IDLE;
                else if (SETTLE == 0) state_nxt = S_SAMPLE;
                else                  state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (!en_cur)                 state_nxt = S_SELECT;
                else if (cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
            end
            // Stability beats timeout when both land on the same compare.
            S_SAMPLE: begin
                if (!en_cur)         state_nxt = S_SELECT;
                else if (stable_hit) state_nxt = S_CAPTURE;
                else if (tmo_hit)    state_nxt = S_ABANDON;
            end
            S_CAPTURE: state_nxt = S_SELECT;
            S_ABANDON: state_nxt = S_SELECT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            stage1     <= '0;
            stage2     <= '0;
            out_q      <= '0;
            ref_val    <= '0;
            cnt        <= '0;
            tmo        <= '0;
            first_smp  <= 1'b0;
            cur_ch     <= '0;
            last_ch    <= CW'(N_CH - 1);
            sync_valid <= '0;
            sync_chg   <= '0;
            ch_timeout <= '0;
        end else begin
            stage1     <= Bus_in_flat;
            stage2     <= stage1;
            sync_valid <= '0;
            sync_chg   <= '0;
            ch_timeout <= '0;
            case (state)
                S_SELECT: begin
                    if (any_en)
                        cur_ch <= next_ch;
                    cnt       <= '0;
                    tmo       <= '0;
                    first_smp <= 1'b1;
                end
                S_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (!en_cur)
                        last_ch <= cur_ch;
                end
                S_SAMPLE: begin
                    if (!en_cur) begin
                        last_ch <= cur_ch;
                    end else begin
                        if (!samp_eq) begin
                            ref_val <= sample;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                        tmo       <= tmo + TW'(1);
                        first_smp <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    out_q[cur_ch]      <= ref_val;
                    sync_valid[cur_ch] <= 1'b1;
                    sync_chg[cur_ch]   <= (ref_val != out_q[cur_ch]);
                    last_ch            <= cur_ch;
                end
                S_ABANDON: begin
                    ch_timeout[cur_ch] <= 1'b1;
                    last_ch            <= cur_ch;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sync_scan_ctrl.sv
// Bench for bus_sync_scan_ctrl: per-visit reference model over pre-generated bus histories,
// plus directed enable-drop and asynchronous-reset scenarios.
module tb_bus_sync_scan_ctrl;
    localparam int BW = 8, NC = 4, SET = 2, STB = 3, TMO = 15, MAXC = 400;

    logic                 dest_clk = 1'b0;
    logic                 dest_rst;
    logic [NC-1:0]        ch_en;
    logic [NC*BW-1:0]     Bus_in_flat, Bus_sync_flat;
    logic [NC-1:0]        sync_valid, sync_chg, ch_timeout;
    logic                 busy;
    logic [1:0]           cur_ch;

    always #5 dest_clk = ~dest_clk;

    bus_sync_scan_ctrl #(.Bus_BW(BW), .N_CH(NC), .SETTLE(SET), .STABLE_CNT(STB), .TIMEOUT(TMO)) dut (
        .dest_clk(dest_clk), .dest_rst(dest_rst), .ch_en(ch_en), .Bus_in_flat(Bus_in_flat),
        .Bus_sync_flat(Bus_sync_flat), .sync_valid(sync_valid), .sync_chg(sync_chg),
        .ch_timeout(ch_timeout), .busy(busy), .cur_ch(cur_ch)
    );

    int total = 0;
    int bad   = 0;

    // bmem[ch][n] is the bus value presented at the n-th rising edge after reset release.
    logic [BW-1:0]    bmem [NC][MAXC];
    logic [NC-1:0]    ev_valid [MAXC];
    logic [NC-1:0]    ev_chg   [MAXC];
    logic [NC-1:0]    ev_tmo   [MAXC];
    logic [NC*BW-1:0] ev_bus   [MAXC];
    int               ev_cur   [MAXC];
    int obs_ch[$], obs_cyc[$], obs_chg[$], obs_all[$];

    // Visit-level model: each visit samples TMO values starting SET+1 cycles after SELECT and
    // succeeds on the first run of STB+1 equal values; the result pulse cycle is the next SELECT.
    task automatic build_model(input logic [NC-1:0] en);
        logic [NC-1:0][BW-1:0] outv;
        logic [BW-1:0] v, prv;
        logic [1:0] chi;
        int last, s, w, ch, hit, run, p, idx;
        for (int c = 0; c < MAXC; c++) begin
            ev_valid[c] = '0; ev_chg[c] = '0; ev_tmo[c] = '0; ev_bus[c] = '0; ev_cur[c] = -1;
        end
        outv = '0; last = NC - 1; s = 1;
        while (s < MAXC - (SET + TMO + 4)) begin
            ch = -1;
            for (int i = 1; i <= NC; i++) begin
                idx = (last + i) % NC;
                if (ch < 0 && en[idx[1:0]]) ch = idx;
            end
            chi = ch[1:0];
            w = s + 1 + SET; hit = -1; run = 0; prv = '0;
            for (int k = 0; k < TMO; k++) begin
                if (hit < 0) begin
                    v = bmem[ch][w + k - 1];
                    if (k == 0 || v != prv) run = 1; else run++;
                    prv = v;
                    if (run == STB + 1) hit = k;
                end
            end
            p = (hit >= 0) ? (w + hit + 2) : (w + TMO + 1);
            for (int c = s; c < p; c++) ev_bus[c] = outv;
            if (hit >= 0) begin
                ev_valid[p] = ev_valid[p] | NC'(1 << ch);
                if (prv != outv[chi]) ev_chg[p] = ev_chg[p] | NC'(1 << ch);
                outv[chi] = prv;
            end else begin
                ev_tmo[p] = ev_tmo[p] | NC'(1 << ch);
            end
            ev_cur[p] = ch;
            last = ch; s = p;
        end
        for (int c = s; c < MAXC; c++) ev_bus[c] = outv;
    endtask

    task automatic fill_const(input int ch, input logic [BW-1:0] v);
        for (int n = 0; n < MAXC; n++) bmem[ch][n] = v;
    endtask

    task automatic fill_static_rand();
        for (int i = 0; i < NC; i++) fill_const(i, BW'($urandom_range(1, 255)));
    endtask

    task automatic drive_bus(input int n);
        for (int i = 0; i < NC; i++) Bus_in_flat[i*BW +: BW] = bmem[i][n];
    endtask

    task automatic do_reset(input logic [NC-1:0] en);
        @(negedge dest_clk);
        dest_rst = 1'b1; ch_en = en; Bus_in_flat = '0;
        @(negedge dest_clk);
        @(negedge dest_clk);
        dest_rst = 1'b0;
    endtask

    task automatic run_scen(input logic [NC-1:0] en, input int ncyc);
        build_model(en);
        obs_ch.delete(); obs_cyc.delete(); obs_chg.delete(); obs_all.delete();
        do_reset(en);
        for (int n = 1; n <= ncyc; n++) begin
            drive_bus(n);
            @(posedge dest_clk); #1;
            total++;
            if (sync_valid !== ev_valid[n]) begin bad++; $display("FAIL sync_valid cyc=%0d got=%b exp=%b", n, sync_valid, ev_valid[n]); end
            total++;
            if (sync_chg !== ev_chg[n]) begin bad++; $display("FAIL sync_chg cyc=%0d got=%b exp=%b", n, sync_chg, ev_chg[n]); end
            total++;
            if (ch_timeout !== ev_tmo[n]) begin bad++; $display("FAIL ch_timeout cyc=%0d got=%b exp=%b", n, ch_timeout, ev_tmo[n]); end
            total++;
            if (Bus_sync_flat !== ev_bus[n]) begin bad++; $display("FAIL bus_sync cyc=%0d got=%h exp=%h", n, Bus_sync_flat, ev_bus[n]); end
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=1", n, busy); end
            if (ev_cur[n] >= 0) begin
                total++;
                if (cur_ch !== 2'(ev_cur[n])) begin bad++; $display("FAIL cur_ch cyc=%0d got=%0d exp=%0d", n, cur_ch, ev_cur[n]); end
            end
            for (int i = 0; i < NC; i++) begin
                if (sync_valid[i[1:0]] === 1'b1) begin
                    obs_ch.push_back(i); obs_cyc.push_back(n);
                    obs_chg.push_back(int'(sync_chg[i[1:0]])); obs_all.push_back(i);
                end
                if (ch_timeout[i[1:0]] === 1'b1) obs_all.push_back(16 + i);
            end
            @(negedge dest_clk);
        end
    endtask

    task automatic test_reset();
        dest_rst = 1'b1; ch_en = '1; Bus_in_flat = '1;
        #1;
        total++;
        if ({Bus_sync_flat, sync_valid, sync_chg, ch_timeout, busy, cur_ch} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h/%b/%b/%b/%b/%0d exp=all zero",
                            Bus_sync_flat, sync_valid, sync_chg, ch_timeout, busy, cur_ch);
        end
        repeat (3) @(posedge dest_clk);
        #1;
        total++;
        if ({Bus_sync_flat, sync_valid, busy, cur_ch} !== '0) begin
            bad++; $display("FAIL reset_held got=%h/%b/%b/%0d exp=all zero", Bus_sync_flat, sync_valid, busy, cur_ch);
        end
    endtask

    task automatic test_single_stable();
        fill_static_rand();
        fill_const(0, 8'hA5);
        run_scen(4'b0001, 30);
        total++;
        if (obs_cyc.size() < 2) begin
            bad++; $display("FAIL single_pulses got=%0d exp>=2", obs_cyc.size());
        end else begin
            total++;
            if (obs_cyc[0] != 1 + (1 + SET + (STB + 1) + 1)) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", obs_cyc[0], 1 + 1 + SET + STB + 1 + 1); end
            total++;
            if (obs_chg[0] != 1) begin bad++; $display("FAIL single_first_chg got=%0d exp=1", obs_chg[0]); end
            total++;
            if (obs_chg[1] != 0) begin bad++; $display("FAIL single_second_chg got=%0d exp=0", obs_chg[1]); end
            total++;
            if (obs_cyc[1] - obs_cyc[0] != 8) begin bad++; $display("FAIL single_revisit got=%0d exp=8", obs_cyc[1] - obs_cyc[0]); end
        end
        total++;
        if (Bus_sync_flat[7:0] !== 8'hA5) begin bad++; $display("FAIL single_value got=%h exp=a5", Bus_sync_flat[7:0]); end
    endtask

    task automatic test_scan_order();
        int exp_ord [6] = '{0, 1, 3, 0, 1, 3};
        fill_static_rand();
        run_scen(4'b1011, 60);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= obs_ch.size()) begin bad++; $display("FAIL order_missing idx=%0d got=none exp=%0d", i, exp_ord[i]); end
            else if (obs_ch[i] != exp_ord[i]) begin bad++; $display("FAIL order idx=%0d got=%0d exp=%0d", i, obs_ch[i], exp_ord[i]); end
        end
        total++;
        if (Bus_sync_flat[23:16] !== 8'h00) begin bad++; $display("FAIL order_ch2_untouched got=%h exp=00", Bus_sync_flat[23:16]); end
    endtask

    task automatic test_timeout();
        int exp_all [4] = '{0, 17, 0, 17};
        fill_static_rand();
        for (int n = 0; n < MAXC; n++) bmem[1][n] = n[0] ? 8'hFF : 8'h00;
        run_scen(4'b0011, 70);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= obs_all.size()) begin bad++; $display("FAIL tmo_seq_missing idx=%0d got=none exp=%0d", i, exp_all[i]); end
            else if (obs_all[i] != exp_all[i]) begin bad++; $display("FAIL tmo_seq idx=%0d got=%0d exp=%0d", i, obs_all[i], exp_all[i]); end
        end
        total++;
        if (Bus_sync_flat[15:8] !== 8'h00) begin bad++; $display("FAIL tmo_ch1_unchanged got=%h exp=00", Bus_sync_flat[15:8]); end
    endtask

    task automatic test_midchange();
        fill_static_rand();
        for (int n = 0; n < MAXC; n++) bmem[2][n] = (n < 5) ? 8'h11 : 8'h3C;
        run_scen(4'b0100, 30);
        total++;
        if (obs_cyc.size() < 1) begin
            bad++; $display("FAIL mid_no_capture got=0 exp>=1");
        end else begin
            total++;
            if (obs_cyc[0] != 11) begin bad++; $display("FAIL mid_cycle got=%0d exp=11", obs_cyc[0]); end
            total++;
            if (obs_chg[0] != 1) begin bad++; $display("FAIL mid_chg got=%0d exp=1", obs_chg[0]); end
        end
        total++;
        if (Bus_sync_flat[23:16] !== 8'h3C) begin bad++; $display("FAIL mid_value got=%h exp=3c", Bus_sync_flat[23:16]); end
    endtask

    task automatic test_random();
        int rates [3] = '{3, 10, 40};
        logic [BW-1:0] v;
        int rate;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < NC; i++) begin
                v = BW'($urandom);
                rate = rates[$urandom_range(0, 2)];
                for (int n = 0; n < MAXC; n++) begin
                    if ($urandom_range(0, rate - 1) == 0) v = BW'($urandom);
                    bmem[i][n] = v;
                end
            end
            run_scen(NC'($urandom_range(1, 15)), 250);
        end
    endtask

    task automatic test_enable_drop();
        do_reset(4'b0011);
        Bus_in_flat = 32'h4433_2211;
        for (int n = 1; n <= 16; n++) begin
            if (n == 5)  ch_en = 4'b0010;
            if (n == 14) ch_en = 4'b0000;
            @(posedge dest_clk); #1;
            if (n <= 12 || n >= 14) begin
                total++;
                if (sync_valid !== 4'b0000 || ch_timeout !== 4'b0000) begin
                    bad++; $display("FAIL drop_no_pulse cyc=%0d got=%b/%b exp=0000/0000", n, sync_valid, ch_timeout);
                end
            end
            if (n == 6) begin
                total++;
                if (cur_ch !== 2'd1) begin bad++; $display("FAIL drop_next_ch got=%0d exp=1", cur_ch); end
                total++;
                if (Bus_sync_flat[7:0] !== 8'h00) begin bad++; $display("FAIL drop_ch0_unchanged got=%h exp=00", Bus_sync_flat[7:0]); end
            end
            if (n == 13) begin
                total++;
                if (sync_valid !== 4'b0010) begin bad++; $display("FAIL drop_ch1_capture got=%b exp=0010", sync_valid); end
            end
            if (n >= 14) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle cyc=%0d got=%b exp=0", n, busy); end
            end
            @(negedge dest_clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(4'b0100);
        Bus_in_flat = 32'h775A_3311;
        for (int n = 1; n <= 13; n++) begin
            @(posedge dest_clk); #1;
            if (n == 9) begin
                total++;
                if (sync_valid !== 4'b0100) begin bad++; $display("FAIL rmid_first got=%b exp=0100", sync_valid); end
            end
            if (n < 13) @(negedge dest_clk);
        end
        total++;
        if (cur_ch !== 2'd2) begin bad++; $display("FAIL rmid_pre_cur got=%0d exp=2", cur_ch); end
        #2 dest_rst = 1'b1;
        #1;
        total++;
        if ({Bus_sync_flat, sync_valid, sync_chg, ch_timeout, busy, cur_ch} !== '0) begin
            bad++; $display("FAIL rmid_async got=%h/%b/%b/%0d exp=all zero", Bus_sync_flat, sync_valid, busy, cur_ch);
        end
        @(negedge dest_clk);
        ch_en = 4'b1101;
        @(negedge dest_clk);
        dest_rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge dest_clk); #1;
            total++;
            if (sync_valid !== ((n == 9) ? 4'b0001 : 4'b0000)) begin
                bad++; $display("FAIL rmid_restart cyc=%0d got=%b exp=%b", n, sync_valid, (n == 9) ? 4'b0001 : 4'b0000);
            end
            @(negedge dest_clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_stable();
        test_scan_order();
        test_timeout();
        test_midchange();
        test_random();
        test_enable_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_sync_scan_ctrl.md
Name: bus_sync_scan_ctrl

Overview:
Shared stability-qualification scheduler for multi-bit quasi-static buses entering the dest_clk domain.
- Each of N_CH source buses gets its own 2-flop front end.
- One comparator, stability counter and timeout counter are time-shared across channels by a round-robin FSM.
- A channel's output register updates only after its bus has held one value for STABLE_CNT consecutive compares.
- Sits at the clock-domain boundary, feeding configuration/status registers that change rarely.

Parameters:
Bus_BW, 8, width of each channel bus
N_CH, 4, number of channels (2..16)
SETTLE, 2, dead cycles after switching channel before sampling (0..15)
STABLE_CNT, 3, consecutive equal compares required (1..15)
TIMEOUT, 15, max SAMPLE cycles per visit before abandoning (must be > STABLE_CNT)

Ports:
dest_clk  in  1  destination clock
dest_rst  in  1  asynchronous reset, active-high
ch_en  in  N_CH  per-channel scan enable (dest_clk domain)
Bus_in_flat  in  N_CH*Bus_BW  async source buses; channel i at [i*Bus_BW +: Bus_BW]
Bus_sync_flat  out  N_CH*Bus_BW  qualified per-channel values, same packing
sync_valid  out  N_CH  1-cycle pulse: channel i output register written
sync_chg  out  N_CH  1-cycle pulse, coincident with sync_valid: written value differs from previous
ch_timeout  out  N_CH  1-cycle pulse: channel i visit abandoned, no stable value
busy  out  1  FSM not in IDLE
cur_ch  out  $clog2(N_CH)  channel currently selected

Behaviour:
- Reset (dest_rst=1, async): all front-end flops, ref_val, counters, Bus_sync_flat, sync_valid, sync_chg, ch_timeout, busy, cur_ch -> 0. FSM -> IDLE. Last-served pointer -> N_CH-1, so channel 0 is first. Reset mid-visit discards that visit with no pulses.
- Front end: stage1 <= Bus_in_flat; stage2 <= stage1, every cycle for all channels. Sample value = stage2 slice of cur_ch.
- FSM states: IDLE, SELECT, SETTLE, SAMPLE, CAPTURE, ABANDON.
- IDLE: stays while ch_en==0. Otherwise -> SELECT.
- SELECT (1 cycle): cur_ch <= first enabled channel searching upward from last+1, wrapping modulo N_CH. Clears cnt and tmo.
  - If ch_en==0 in this cycle -> IDLE.
  - Else -> SETTLE, or directly -> SAMPLE if SETTLE==0.
- SETTLE: counts SETTLE cycles, then -> SAMPLE.
- SAMPLE:
  - First cycle: ref_val <= sample, cnt <= 0.
  - Each later cycle, if sample==ref_val then cnt++. Otherwise ref_val <= sample and cnt <= 0.
  - tmo increments every SAMPLE cycle.
  - Exit to CAPTURE when cnt reaches STABLE_CNT.
  - Otherwise exit to ABANDON when tmo reaches TIMEOUT.
  - If both occur in the same cycle, CAPTURE wins.
- CAPTURE (1 cycle): Bus_sync slice of cur_ch <= ref_val. Pulses sync_valid[cur_ch], and sync_chg[cur_ch] if the value changed. last <= cur_ch. -> SELECT.
- ABANDON (1 cycle): pulses ch_timeout[cur_ch]. Output register unchanged. last <= cur_ch. -> SELECT.
- Enable removal mid-visit: if ch_en[cur_ch] drops during SETTLE or SAMPLE, go to SELECT next cycle.
  - No pulses, output unchanged, last <= cur_ch.
- Enable changes for other channels take effect at the next SELECT.
- Latency for a stable channel: SELECT to sync_valid pulse = 1 + SETTLE + (STABLE_CNT+1) + 1 cycles; defaults give 8.
- Single enabled channel: revisited back-to-back.
- Outputs are registered; pulses never overlap across channels.
- busy = (state != IDLE).

Test Plan:
- Reset; ch_en=4'b0001; ch0 held 8'hA5 -> sync_valid[0] and sync_chg[0] 8 cycles after SELECT, Bus_sync ch0=8'hA5. The next visit gives sync_valid[0] with sync_chg[0]=0.
- ch_en=4'b1011, all buses static -> visit order 0,1,3,0,1,3. Channel 2 is never selected and its output stays 0.
- ch1 toggles 8'h00/8'hFF every cycle -> ch_timeout[1] pulses, Bus_sync ch1 unchanged, scan continues to the next enabled channel.
- ch2 changes once mid-SAMPLE to 8'h3C, then holds -> count restarts. Capture of 8'h3C occurs before TIMEOUT, with sync_chg[2]=1.
- Clear ch_en[cur_ch] during SAMPLE -> no pulse, FSM moves to the next channel within 2 cycles. Set ch_en=0 -> busy=0 after the current SELECT.
- Assert dest_rst mid-SAMPLE -> all outputs 0 immediately, with no clock needed. After release, scanning restarts at channel 0.
